// File: rtl/lfsr_burst_ctrl.sv
// Burst sequencer that drives an external 8-bit LFSR and streams its words.
// Optional first-word wrap detection under `LFSR_BURST_CTRL_WRAP_EN.
module lfsr_burst_ctrl (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic       i_reseed,
  input  logic [7:0] i_seed,
  input  logic [7:0] i_len,
  input  logic       i_ready,
  input  logic [7:0] i_lfsr_data,
  output logic       o_lfsr_valid,
  output logic       o_lfsr_soft_reset,
  output logic [7:0] o_lfsr_seed,
  output logic [7:0] o_data,
  output logic       o_data_valid,
  output logic       o_busy,
  output logic       o_done,
  output logic [8:0] o_words_left,
  output logic       o_wrap
);

  typedef enum logic [2:0] {
    IDLE, SEED, STEP, CAPT, WAIT, DONE
  } state_t;

  state_t state_q, state_d;

  logic start_acc;
  logic hs;
  logic capt;

  assign start_acc = (state_q == IDLE)
                   && i_start && !i_abort;
  assign hs   = (state_q == WAIT) && i_ready;
  assign capt = (state_q == CAPT) && !i_abort;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (i_abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (i_start)
                state_d = i_reseed ? SEED : STEP;
        SEED: state_d = STEP;
        STEP: state_d = CAPT;
        CAPT: state_d = WAIT;
        WAIT: if (i_ready)
                state_d = (o_words_left == 9'd1)
                        ? DONE : STEP;
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Abort suppresses a pending done pulse in the same cycle.
  always_comb begin
    o_lfsr_valid      = 1'b0;
    o_lfsr_soft_reset = 1'b0;
    o_data_valid      = 1'b0;
    o_done            = 1'b0;
    o_busy            = (state_q != IDLE);
    unique case (state_q)
      SEED: o_lfsr_soft_reset = 1'b1;
      STEP: o_lfsr_valid      = 1'b1;
      WAIT: o_data_valid      = 1'b1;
      DONE: o_done            = !i_abort;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_lfsr_seed  <= 8'h01;
      o_data       <= 8'h00;
      o_words_left <= 9'd0;
    end else begin
      if (start_acc) begin
        o_lfsr_seed  <= i_seed;
        o_words_left <= (i_len == 8'd0)
                      ? 9'd256 : {1'b0, i_len};
      end else if (i_abort) begin
        o_words_left <= 9'd0;
      end else if (hs) begin
        o_words_left <= o_words_left - 9'd1;
      end
      if (capt) o_data <= i_lfsr_data;
    end
  end

`ifdef LFSR_BURST_CTRL_WRAP_EN
  logic [7:0] first_q;
  logic       first_seen_q;
  logic       wrap_q;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      first_q      <= 8'h00;
      first_seen_q <= 1'b0;
      wrap_q       <= 1'b0;
    end else if (start_acc) begin
      first_seen_q <= 1'b0;
      wrap_q       <= 1'b0;
    end else if (capt) begin
      if (!first_seen_q) begin
        first_q      <= i_lfsr_data;
        first_seen_q <= 1'b1;
      end else if (i_lfsr_data == first_q) begin
        wrap_q <= 1'b1;
      end
    end
  end

  assign o_wrap = wrap_q;
`else
  assign o_wrap = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_burst_ctrl.sv
// Directed bench for lfsr_burst_ctrl with an 8-bit Fibonacci LFSR
// (x^8+x^6+x^5+x^4+1, left shift) attached to the LFSR ports.
module tb_lfsr_burst_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort, reseed, ready;
  logic [7:0] seed, len;
  logic [7:0] lfsr;
  logic       lfsr_valid, lfsr_soft;
  logic [7:0] lfsr_seed, data;
  logic       data_valid, busy, done, wrap;
  logic [8:0] words;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  lfsr_burst_ctrl dut (
    .clk              (clk),
    .i_rst_n          (rst_n),
    .i_start          (start),
    .i_abort          (abort),
    .i_reseed         (reseed),
    .i_seed           (seed),
    .i_len            (len),
    .i_ready          (ready),
    .i_lfsr_data      (lfsr),
    .o_lfsr_valid     (lfsr_valid),
    .o_lfsr_soft_reset(lfsr_soft),
    .o_lfsr_seed      (lfsr_seed),
    .o_data           (data),
    .o_data_valid     (data_valid),
    .o_busy           (busy),
    .o_done           (done),
    .o_words_left     (words),
    .o_wrap           (wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         lfsr <= 8'h01;
    else if (lfsr_soft) lfsr <= lfsr_seed;
    else if (lfsr_valid)
      lfsr <= {lfsr[6:0],
               lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  always @(posedge clk) if (done) done_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_ctl"},
          {28'd0, busy, lfsr_valid, lfsr_soft, data_valid},
          32'd0);
    check({tag, "_done_wrap"}, {30'd0, done, wrap}, 32'd0);
    check({tag, "_seed"}, {24'd0, lfsr_seed}, 32'h01);
    check({tag, "_data"}, {24'd0, data}, 32'h00);
    check({tag, "_words"}, {23'd0, words}, 32'd0);
  endtask

  logic [7:0] exp_a [3];
  logic       exp_wrap;
  int         d0, hs_cnt;
  logic [7:0] first_word;
  logic       seen;

  initial begin
    exp_a[0] = 8'h02;
    exp_a[1] = 8'h04;
    exp_a[2] = 8'h08;
`ifdef LFSR_BURST_CTRL_WRAP_EN
    exp_wrap = 1'b1;
`else
    exp_wrap = 1'b0;
`endif
    rst_n = 1'b0; start = 0; abort = 0; reseed = 0;
    ready = 0; seed = 8'h00; len = 8'h00;
    tick();
    tick();
    check_reset_outs("rst");
    rst_n = 1'b1;
    tick();

    // Reseed burst, len 3, ready high throughout
    start = 1; reseed = 1; seed = 8'h01; len = 8'd3;
    ready = 1;
    tick();
    start = 0; reseed = 0; seed = 8'hAA;
    check("a_seed_state",
          {29'd0, busy, lfsr_soft, lfsr_valid}, 32'b110);
    check("a_seed_val", {24'd0, lfsr_seed}, 32'h01);
    tick();
    check("a_step",
          {30'd0, lfsr_soft, lfsr_valid}, 32'b01);
    tick();
    check("a_capt_novalid", {31'd0, data_valid}, 32'd0);
    tick();
    check("a_w0_valid", {31'd0, data_valid}, 32'd1);
    check("a_w0_data", {24'd0, data}, {24'd0, exp_a[0]});
    check("a_w0_words", {23'd0, words}, 32'd3);
    for (int i = 1; i < 3; i++) begin
      tick();
      check("a_step_n", {31'd0, lfsr_valid}, 32'd1);
      tick();
      tick();
      check("a_wn_data", {24'd0, data}, {24'd0, exp_a[i]});
      check("a_wn_words", {23'd0, words}, 3 - i);
    end
    d0 = done_cnt;
    tick();
    check("a_done", {31'd0, done}, 32'd1);
    check("a_done_words", {23'd0, words}, 32'd0);
    tick();
    check("a_idle", {30'd0, busy, done}, 32'd0);
    check("a_done_cnt", done_cnt, d0 + 1);
    check("a_seed_hold", {24'd0, lfsr_seed}, 32'h01);

    // Backpressure, len 2, no reseed (LFSR continues from 0x08)
    start = 1; reseed = 0; len = 8'd2; ready = 0;
    tick();
    start = 0;
    tick();
    tick();
    check("b_latency2", {31'd0, data_valid}, 32'd1);
    check("b_w0_data", {24'd0, data}, 32'h11);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("b_hold",
            {21'd0, data_valid, lfsr_valid, data, words},
            {21'd0, 1'b1, 1'b0, 8'h11, 9'd2});
    end
    ready = 1;
    tick();
    check("b_hs_words", {23'd0, words}, 32'd1);
    check("b_hs_novalid", {31'd0, data_valid}, 32'd0);
    tick();
    tick();
    check("b_w1_data", {24'd0, data}, 32'h23);
    tick();
    check("b_done", {31'd0, done}, 32'd1);
    tick();

    // Abort in WAIT with 5 words left; start ignored while busy
    start = 1; len = 8'd5; ready = 0;
    tick();
    start = 0;
    tick();
    tick();
    check("c_words5", {23'd0, words}, 32'd5);
    check("c_data", {24'd0, data}, 32'h47);
    start = 1; len = 8'd9;
    tick();
    start = 0;
    check("c_start_ignored",
          {21'd0, busy, data_valid, 9'd0, words},
          {21'd0, 1'b1, 1'b1, 9'd0, 9'd5});
    d0 = done_cnt;
    abort = 1;
    tick();
    abort = 0;
    check("c_abort",
          {20'd0, busy, data_valid, done, words},
          32'd0);
    tick();
    check("c_no_done", done_cnt, d0);

    // Abort and start together in IDLE
    start = 1; abort = 1; len = 8'd4;
    tick();
    start = 0; abort = 0;
    check("d_abort_wins",
          {22'd0, busy, words}, 32'd0);
    tick();
    check("d_still_idle", {31'd0, busy}, 32'd0);

    // Length 0 means 256 words; reseed 0x01 exercises wrap
    start = 1; reseed = 1; seed = 8'h01; len = 8'd0;
    ready = 1;
    tick();
    start = 0; reseed = 0;
    check("e_words256", {23'd0, words}, 32'd256);
    d0 = done_cnt;
    hs_cnt = 0;
    seen = 0;
    first_word = 8'h00;
    for (int i = 0; i < 1200 && !seen; i++) begin
      tick();
      if (data_valid) begin
        if (hs_cnt == 0) first_word = data;
        hs_cnt++;
      end
      if (done) seen = 1;
    end
    check("e_done_seen", {31'd0, seen}, 32'd1);
    check("e_hs_cnt", hs_cnt, 256);
    check("e_first", {24'd0, first_word}, 32'h02);
    tick();
    check("e_done_cnt", done_cnt, d0 + 1);
    check("e_wrap", {31'd0, wrap}, {31'd0, exp_wrap});
    check("e_idle", {31'd0, busy}, 32'd0);

    // Reset while in STEP takes effect without a clock edge
    start = 1; reseed = 0; seed = 8'h5A; len = 8'd4;
    tick();
    start = 0;
    check("f_in_step", {31'd0, lfsr_valid}, 32'd1);
    check("f_seed_latched", {24'd0, lfsr_seed}, 32'h5A);
    d0 = done_cnt;
    #1 rst_n = 1'b0;
    #1;
    check_reset_outs("f_async");
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("f_post_idle", {31'd0, busy}, 32'd0);
    check("f_no_done", done_cnt, d0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_burst_ctrl.md
LFSR_BURST_CTRL -- requirements
Module: lfsr_burst_ctrl

Interface
REQ-001 The block SHALL have one clock and SHALL use an asynchronous, active-low reset.
REQ-002 Port list SHALL be, in order:
- clk  input  1  rising-edge clock
- i_rst_n  input  1  asynchronous active-low reset
- i_start  input  1  burst request, sampled in IDLE only
- i_abort  input  1  cancel the current burst
- i_reseed  input  1  reseed the LFSR before the burst, sampled with i_start
- i_seed  input  8  seed value, sampled with i_start
- i_len  input  8  burst length in words; 0 means 256
- i_ready  input  1  downstream accepts o_data
- i_lfsr_data  input  8  current LFSR state
- o_lfsr_valid  output  1  advance-LFSR strobe
- o_lfsr_soft_reset  output  1  LFSR load strobe
- o_lfsr_seed  output  8  seed driven to the LFSR
- o_data  output  8  captured pseudo-random word
- o_data_valid  output  1  o_data is valid
- o_busy  output  1  FSM is not IDLE
- o_done  output  1  one-cycle burst-complete pulse
- o_words_left  output  9  words still to deliver
- o_wrap  output  1  sticky sequence-wrap flag

Function
REQ-003 The FSM SHALL have the states IDLE, SEED, STEP, CAPT, WAIT and DONE, held in registers.
REQ-004 In IDLE, when i_start=1 and i_abort=0, the block SHALL latch i_seed, set o_words_left to i_len (or 256 if i_len=0), and go to SEED if i_reseed=1, otherwise to STEP.
REQ-005 SEED SHALL assert o_lfsr_soft_reset for exactly one cycle with o_lfsr_seed equal to the latched seed, then go to STEP.
REQ-006 STEP SHALL assert o_lfsr_valid for exactly one cycle, then go to CAPT.
REQ-007 CAPT SHALL register i_lfsr_data into o_data, set o_data_valid=1, and go to WAIT.
REQ-008 In WAIT, o_data and o_data_valid SHALL hold until i_ready=1.
REQ-009 On the WAIT handshake, o_data_valid SHALL clear, o_words_left SHALL decrement, and the FSM SHALL go to DONE if o_words_left was 1, otherwise to STEP.
REQ-010 DONE SHALL pulse o_done for one cycle and return to IDLE.
REQ-011 Minimum spacing between accepted words SHALL be 3 cycles; burst latency from i_start to the first o_data_valid SHALL be 2 cycles without reseed and 3 cycles with reseed.
REQ-012 o_lfsr_valid and o_lfsr_soft_reset SHALL never be asserted in the same cycle.
REQ-013 o_lfsr_seed SHALL hold the last latched seed at all times.
REQ-014 o_busy SHALL be 1 in every state except IDLE.
REQ-015 i_start SHALL be ignored in every state other than IDLE.
REQ-016 i_abort=1 in any non-IDLE state SHALL force IDLE on the next edge, clear o_data_valid and o_words_left, and produce no o_done pulse.
REQ-017 If i_abort=1 and i_start=1 arrive together in IDLE, abort SHALL win and the burst SHALL not start.
REQ-018 If i_abort and a WAIT handshake occur in the same cycle, the word SHALL count as delivered, but abort SHALL still take effect with no o_done pulse.
REQ-019 If i_ready=1 outside WAIT, it SHALL have no effect.

Reset
REQ-020 While i_rst_n=0, the FSM SHALL be in IDLE.
REQ-021 While i_rst_n=0, o_lfsr_seed SHALL be 0x01 and o_data SHALL be 0x00.
REQ-022 While i_rst_n=0, o_words_left SHALL be 0.
REQ-023 While i_rst_n=0, all other outputs SHALL be 0.
REQ-024 Assertion of reset in the middle of a burst SHALL discard the burst without an o_done pulse; deassertion SHALL take effect on the next clk edge.

Configuration
REQ-025 With macro LFSR_BURST_CTRL_WRAP_EN defined, the block SHALL store the first word captured in each burst.
REQ-026 With LFSR_BURST_CTRL_WRAP_EN defined, o_wrap SHALL set when any later captured word in the same burst equals that stored first word, and SHALL stay set until the next accepted i_start.
REQ-027 Without LFSR_BURST_CTRL_WRAP_EN, o_wrap SHALL be tied to 0 and no comparison storage SHALL be built.

Verification (bench instantiates the team 8-bit LFSR on the o_lfsr_* and i_lfsr_data ports)
REQ-028 Reseed burst: i_reseed=1, i_seed=0x01, i_len=3, i_ready=1 -> o_data sequence 0x02, 0x04, 0x08; o_done pulses once; o_busy returns to 0.
REQ-029 Backpressure: i_len=2, i_ready=0 for 10 cycles after the first o_data_valid -> o_data is stable for all 10 cycles, o_lfsr_valid stays 0, and o_words_left stays 2 until the handshake.
REQ-030 Abort: i_abort=1 in WAIT with o_words_left=5 -> IDLE on the next cycle, o_data_valid=0, o_words_left=0, and no o_done pulse.
REQ-031 Length zero: i_len=0x00, i_ready=1 -> exactly 256 handshakes, then one o_done pulse.
REQ-032 Reset mid-burst: drop i_rst_n during STEP -> all outputs take their REQ-021 to REQ-023 values immediately, with no clk edge needed.
REQ-033 Wrap, macro defined: i_len=0, seed 0x01 with reseed -> o_wrap becomes 1 once the LFSR period completes; with the macro undefined, o_wrap stays 0.
